// File: rtl/axis_pcie_rx_slot_serializer_pkg.sv
// Shared constants and payload types for the PCIe RX slot serializer.
// Each RX channel slot carries AXIS_PCIE_DW data bits and AXIS_PCIE_RX_UW user bits.
package axis_pcie_rx_slot_serializer_pkg;

   localparam int unsigned FIM_PCIE_TLP_CH = 2;
   localparam int unsigned AXIS_PCIE_DW    = 64;
   localparam int unsigned AXIS_PCIE_RX_UW = 8;
   localparam int unsigned RX_UW_VLD_BIT   = 0;
   localparam int unsigned RX_UW_EOP_BIT   = 1;

   // One channel slot as held in the capture buffer
   typedef struct packed {
      logic [AXIS_PCIE_RX_UW-1:0] tuser;
      logic [AXIS_PCIE_DW-1:0]    tdata;
   } t_rx_slot;

   // Full multi-slot RX beat as produced by the upstream pipeline
   typedef struct packed {
      logic                                       tvalid;
      logic [FIM_PCIE_TLP_CH*AXIS_PCIE_DW-1:0]    tdata;
      logic                                       tlast;
      logic [FIM_PCIE_TLP_CH*AXIS_PCIE_RX_UW-1:0] tuser;
   } t_axis_pcie_rxs;

endpackage

// File: rtl/axis_pcie_rx_slot_serializer_if.sv
// Multi-slot PCIe RX AXIS beat; ready travels separately as s_if_tready.
interface axis_pcie_rx_slot_serializer_if import axis_pcie_rx_slot_serializer_pkg::*; #(
   parameter int unsigned NUM_CH = FIM_PCIE_TLP_CH
);
   logic                               tvalid;
   logic [NUM_CH*AXIS_PCIE_DW-1:0]     tdata;
   logic                               tlast;
   logic [NUM_CH*AXIS_PCIE_RX_UW-1:0]  tuser;

   modport master (output tvalid, tdata, tlast, tuser);
   modport slave  (input  tvalid, tdata, tlast, tuser);
endinterface

// File: rtl/axis_pcie_rx_slot_serializer_pick.sv
// Lowest-set-bit encoder: index, one-hot of that bit, and an exactly-one-bit-set flag.
module axis_pcie_rx_slot_serializer_pick #(
   parameter int unsigned NUM_CH = 2
) (
   input  logic [NUM_CH-1:0]        mask,
   output logic [$clog2(NUM_CH):0]  idx,
   output logic [NUM_CH-1:0]        onehot,
   output logic                     single
);
   localparam int unsigned CH_W = $clog2(NUM_CH) + 1;

   // Descending scan so the lowest set bit wins
   always_comb begin
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) idx = CH_W'(i);
      end
   end

   assign onehot = mask & (~mask + NUM_CH'(1));
   assign single = (mask != '0) && ((mask & (mask - NUM_CH'(1))) == '0);

endmodule

// File: rtl/axis_pcie_rx_slot_serializer.sv
// Splits each multi-slot PCIe RX beat into single-slot beats, lowest slot first,
// with a one-beat buffer that reloads in the same cycle its last slot leaves.
module axis_pcie_rx_slot_serializer import axis_pcie_rx_slot_serializer_pkg::*; #(
   parameter int unsigned NUM_CH         = FIM_PCIE_TLP_CH,
   parameter bit          TREADY_RST_VAL = 1'b0,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   axis_pcie_rx_slot_serializer_if.slave     s_if,
   output logic                              s_if_tready,
   output logic                              m_tvalid,
   output logic [AXIS_PCIE_DW-1:0]           m_tdata,
   output logic [AXIS_PCIE_RX_UW-1:0]        m_tuser,
   output logic                              m_tlast,
   output logic [$clog2(NUM_CH):0]           m_tch,
   input  logic                              m_tready,
   output logic [CNT_W-1:0]                  empty_beat_cnt
);
   t_rx_slot [NUM_CH-1:0] slots_d;
   t_rx_slot [NUM_CH-1:0] slots_q;
   logic [NUM_CH-1:0]     vld_mask;
   logic [NUM_CH-1:0]     pending_q;
   logic [NUM_CH-1:0]     sel_onehot;
   logic                  sel_single;
   t_rx_slot              sel_slot;
   logic                  accept;
   logic                  xfer;
   logic                  unused_tlast;

   // tlast is not used for framing; slot EOP comes from tuser
   assign unused_tlast = s_if.tlast;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      assign vld_mask[i]      = s_if.tuser[i*AXIS_PCIE_RX_UW + RX_UW_VLD_BIT];
      assign slots_d[i].tuser = s_if.tuser[i*AXIS_PCIE_RX_UW +: AXIS_PCIE_RX_UW];
      assign slots_d[i].tdata = s_if.tdata[i*AXIS_PCIE_DW +: AXIS_PCIE_DW];
   end

   axis_pcie_rx_slot_serializer_pick #(.NUM_CH(NUM_CH)) u_pick (
      .mask   (pending_q),
      .idx    (m_tch),
      .onehot (sel_onehot),
      .single (sel_single)
   );

   always_comb begin
      sel_slot = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_onehot[i]) sel_slot = slots_q[i];
      end
   end

   assign m_tvalid = |pending_q;
   assign m_tdata  = sel_slot.tdata;
   assign m_tuser  = sel_slot.tuser;
   assign m_tlast  = sel_slot.tuser[RX_UW_EOP_BIT];

   // Ready depends only on held state and m_tready, never on s_if.tvalid
   assign s_if_tready = rst_n ? (~|pending_q | (m_tready & sel_single)) : TREADY_RST_VAL;
   assign accept      = s_if.tvalid & s_if_tready;
   assign xfer        = m_tvalid & m_tready;

   // Accept overrides the final-slot clear so the next beat follows with no bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         slots_q   <= '0;
      end else if (accept) begin
         pending_q <= vld_mask;
         slots_q   <= slots_d;
      end else if (xfer) begin
         pending_q <= pending_q & ~sel_onehot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         empty_beat_cnt <= '0;
      end else if (accept && (vld_mask == '0) && (empty_beat_cnt != '1)) begin
         empty_beat_cnt <= empty_beat_cnt + CNT_W'(1);
      end
   end

endmodule
